// File: rtl/fetch_stage.sv
// PC generation and instruction fetch front end: one outstanding memory request feeding a small
// {pc, instr} queue drained by decode. Optional misaligned-redirect trap: TARTARUGA_FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   output logic [31:0] imem_pc_o,
   input  logic [31:0] imem_instr_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        dec_ready_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_pc_o,
   output logic [31:0] fetch_instr_o
`ifdef TARTARUGA_FETCH_MISALIGN_CHECK_EN
   ,
   output logic        fetch_misaligned_o
`endif
);

   localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int CW = $clog2(FQ_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(FQ_DEPTH - 1);
   localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FQ_DEPTH);

   logic [31:0]   r_pc;
   logic          r_inflight;
   logic [31:0]   r_inflight_pc;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_q_pc    [FQ_DEPTH];
   logic [31:0]   r_q_instr [FQ_DEPTH];

   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic [CW:0]   w_occ;
   logic          w_wr_valid;
   logic [PW-1:0] w_wr_sel;
   logic [31:0]   w_wr_pc;
   logic [31:0]   w_wr_instr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   assign w_pop  = fetch_valid_o && dec_ready_i;
   assign w_push = r_inflight && !redirect_valid_i;
   // Occupancy after this cycle's pop, counting the word still in flight.
   assign w_occ  = {1'b0, r_count} - {{CW{1'b0}}, w_pop} + {{CW{1'b0}}, r_inflight};

`ifdef TARTARUGA_FETCH_MISALIGN_CHECK_EN
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic r_halt;
   logic r_q_mis [FQ_DEPTH];
   logic w_mis_redirect;
   logic w_wr_mis;

   assign w_mis_redirect = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
   assign w_issue        = !redirect_valid_i && !r_halt && (w_occ < DEPTH_W);

   always_comb begin
      w_wr_valid = w_push;
      w_wr_sel   = r_wr_ptr;
      w_wr_pc    = r_inflight_pc;
      w_wr_instr = imem_instr_i;
      w_wr_mis   = 1'b0;
      // A misaligned target becomes a single flagged NOP at the head of the flushed queue.
      if (w_mis_redirect) begin
         w_wr_valid = 1'b1;
         w_wr_sel   = '0;
         w_wr_pc    = redirect_pc_i;
         w_wr_instr = NOP_INSTR;
         w_wr_mis   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_halt <= 1'b0;
         for (int i = 0; i < FQ_DEPTH; i++) r_q_mis[i] <= 1'b0;
      end else begin
         if (redirect_valid_i) r_halt <= w_mis_redirect;
         if (w_wr_valid) r_q_mis[w_wr_sel] <= w_wr_mis;
      end
   end

   assign fetch_misaligned_o = r_q_mis[r_rd_ptr];
`else
   assign w_issue = !redirect_valid_i && (w_occ < DEPTH_W);

   always_comb begin
      w_wr_valid = w_push;
      w_wr_sel   = r_wr_ptr;
      w_wr_pc    = r_inflight_pc;
      w_wr_instr = imem_instr_i;
   end
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pc          <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
      end else if (redirect_valid_i) begin
         r_pc       <= redirect_pc_i;
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
`ifdef TARTARUGA_FETCH_MISALIGN_CHECK_EN
         r_wr_ptr   <= w_mis_redirect ? PW'(1) : '0;
         r_count    <= w_mis_redirect ? CW'(1) : '0;
`else
         r_wr_ptr   <= '0;
         r_count    <= '0;
`endif
      end else begin
         if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
         end else begin
            r_inflight <= 1'b0;
         end
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < FQ_DEPTH; i++) begin
            r_q_pc[i]    <= '0;
            r_q_instr[i] <= '0;
         end
      end else if (w_wr_valid) begin
         r_q_pc[w_wr_sel]    <= w_wr_pc;
         r_q_instr[w_wr_sel] <= w_wr_instr;
      end
   end

   assign imem_pc_o     = r_pc;
   assign fetch_valid_o = (r_count != '0);
   assign fetch_pc_o    = r_q_pc[r_rd_ptr];
   assign fetch_instr_o = r_q_instr[r_rd_ptr];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected {pc, instr} pairs, a negedge monitor
// pops and compares every accepted handshake. Memory word at byte address a is a >> 2.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          FQ_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;
`ifdef TARTARUGA_FETCH_MISALIGN_CHECK_EN
   logic        fetch_mis;
`endif

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .imem_pc_o        (imem_pc),
      .imem_instr_i     (imem_instr),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .dec_ready_i      (dec_ready),
      .fetch_valid_o    (fetch_valid),
      .fetch_pc_o       (fetch_pc),
      .fetch_instr_o    (fetch_instr)
`ifdef TARTARUGA_FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misaligned_o (fetch_mis)
`endif
   );

   // Synchronous instruction memory: one-cycle registered read.
   always @(posedge clk) imem_instr <= {2'b00, imem_pc[31:2]};

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_stream(input logic [31:0] pc0, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = pc0 + 32'(4 * i);
         exp_q.push_back('{pc: a, instr: {2'b00, a[31:2]}, mis: 1'b0});
      end
   endtask

   task automatic drain(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         tick();
         k++;
      end
      dec_ready = 1'b0;
      check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Monitor: every accepted handshake outside a redirect cycle must match the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      int   occ;
      if (rstn && fetch_valid && dec_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pop: got pc %h instr %h, required no entry", fetch_pc, fetch_instr);
         end else begin
            e = exp_q.pop_front();
            $display("pop pc=%h instr=%h (exp pc=%h instr=%h)", fetch_pc, fetch_instr, e.pc, e.instr);
            check("pop_pc", fetch_pc, e.pc);
            check("pop_instr", fetch_instr, e.instr);
`ifdef TARTARUGA_FETCH_MISALIGN_CHECK_EN
            check("pop_mis", {31'b0, fetch_mis}, {31'b0, e.mis});
`endif
         end
      end
      // A capture must never land in a full queue.
      if (rstn && dut.r_inflight && !redirect_valid) begin
         occ = int'(dut.r_count) - int'(fetch_valid && dec_ready);
         check("no_full_push", 32'(occ < FQ_DEPTH), 32'd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      rstn           = 1'b0;
      dec_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) tick();
      check("rst_imem_pc", imem_pc, RESET_PC);
      check("rst_valid", {31'b0, fetch_valid}, 32'd0);
      check("rst_pc", fetch_pc, 32'd0);
      check("rst_instr", fetch_instr, 32'd0);

      // Stream from reset, 2-cycle latency, then 5 cycles of backpressure.
      expect_stream(RESET_PC, 8);
      rstn      = 1'b1;
      dec_ready = 1'b1;
      check("lat_c0_valid", {31'b0, fetch_valid}, 32'd0);
      tick();
      check("lat_c1_valid", {31'b0, fetch_valid}, 32'd0);
      tick();
      check("lat_c2_valid", {31'b0, fetch_valid}, 32'd1);
      tick();
      tick();
      dec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'b0, fetch_valid}, 32'd1);
         check("stall_pc", fetch_pc, 32'h8);
         check("stall_instr", fetch_instr, 32'h2);
         if (i == 4) check("stall_imem_pc", imem_pc, 32'h10);
         tick();
      end
      dec_ready = 1'b1;
      drain("stream");

      // Redirect while the queue is full and decode is stalled.
      repeat (3) tick();
      check("pre_redir_valid", {31'b0, fetch_valid}, 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      exp_q.delete();
      expect_stream(32'h40, 4);
      tick();
      redirect_valid = 1'b0;
      check("redir_r1_imem_pc", imem_pc, 32'h40);
      check("redir_r1_valid", {31'b0, fetch_valid}, 32'd0);
      tick();
      check("redir_r2_valid", {31'b0, fetch_valid}, 32'd0);
      tick();
      check("redir_r3_valid", {31'b0, fetch_valid}, 32'd1);
      check("redir_r3_pc", fetch_pc, 32'h40);
      check("redir_r3_instr", fetch_instr, 32'h10);
      dec_ready = 1'b1;
      drain("redirect");

      // Back-to-back redirects: the second target wins.
      dec_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      exp_q.delete();
      expect_stream(32'h200, 4);
      tick();
      redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      check("b2b_imem_pc", imem_pc, 32'h200);
      drain("back2back");

      // Address wrap.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      exp_q.delete();
      expect_stream(32'hFFFF_FFF8, 4);
      dec_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      drain("wrap");

      // Misaligned redirect target.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h42;
      exp_q.delete();
`ifdef TARTARUGA_FETCH_MISALIGN_CHECK_EN
      exp_q.push_back('{pc: 32'h42, instr: 32'h13, mis: 1'b1});
`else
      expect_stream(32'h42, 3);
`endif
      dec_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      drain("misalign");
`ifdef TARTARUGA_FETCH_MISALIGN_CHECK_EN
      dec_ready = 1'b1;
      repeat (8) tick();
      check("halt_valid", {31'b0, fetch_valid}, 32'd0);
      check("halt_imem_pc", imem_pc, 32'h42);
      dec_ready = 1'b0;
`endif

      // Asynchronous reset in the middle of a stream.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      exp_q.delete();
      expect_stream(32'h80, 20);
      dec_ready = 1'b1;
      tick();
      redirect_valid = 1'b0;
      repeat (4) tick();
      check("pre_areset_valid", {31'b0, fetch_valid}, 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("areset_valid", {31'b0, fetch_valid}, 32'd0);
      check("areset_imem_pc", imem_pc, RESET_PC);
      check("areset_pc", fetch_pc, 32'd0);
      exp_q.delete();
      tick();
      tick();
      expect_stream(RESET_PC, 4);
      rstn = 1'b1;
      check("post_areset_valid", {31'b0, fetch_valid}, 32'd0);
      drain("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Program-counter and instruction-fetch front end for the tartaruga core. It generates the PC, drives the synchronous instruction memory, and pairs each returned word with its PC. It buffers fetched instructions in a small queue and hands them to decode through a valid/ready handshake. Execute-stage redirects (branches and jumps) flush all fetched state.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `FQ_DEPTH`, default 2: instruction queue entries; minimum 2.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rstn_i` input 1: reset, asynchronous, active-low.
- `imem_pc_o` output 32: byte address to the instruction memory; equals `pc_q`.
- `imem_instr_i` input 32: memory read data, registered inside the memory, valid one cycle after the address.
- `redirect_valid_i` input 1: execute requests a PC change.
- `redirect_pc_i` input 32: redirect target.
- `dec_ready_i` input 1: decode accepts the queue head this cycle.
- `fetch_valid_o` output 1: queue head is valid.
- `fetch_pc_o` output 32: PC of the queue head.
- `fetch_instr_o` output 32: instruction word of the queue head.

## Operation
- **State:**
  - `pc_q`: next address to request.
  - `inflight_q` and `inflight_pc_q`: one outstanding memory request.
  - Circular queue of {pc, instr} with read/write pointers and a count `0..FQ_DEPTH`.
- **Issue condition:** `!redirect_valid_i && (count - pop + inflight_q) < FQ_DEPTH`, where `pop = fetch_valid_o && dec_ready_i`.
  - On issue: `inflight_q <= 1`, `inflight_pc_q <= pc_q`, `pc_q <= pc_q + 4` (mod 2^32, wraps `FFFF_FFFC` to `0`).
  - No issue: `pc_q` holds and `inflight_q <= 0`. The memory still reads `imem_pc_o`; that data is ignored.
- **Capture:** when `inflight_q == 1` and there is no redirect, push {`inflight_pc_q`, `imem_instr_i`} at the tail.
  - The issue rule guarantees space, counting a same-cycle pop.
  - A push into a full queue is impossible. The bench asserts this.
- **Pop:** `fetch_valid_o = (count != 0)`. Head fields come straight from queue storage. A simultaneous push and pop leaves the count unchanged.
- **Redirect** has priority over everything in that cycle:
  - Count and pointers are cleared.
  - `inflight_q <= 0`; the returning word is discarded.
  - `pc_q <= redirect_pc_i`.
  - No push, and no issue.
  - A pop in the same cycle is still a legal handshake from decode's view, but the entry is flushed.
- Redirects on consecutive cycles: the last one wins. Each flushes again.
- `redirect_pc_i` bits [1:0] are not checked unless the macro below is enabled.

## Timing
- **Reset values:** `imem_pc_o = RESET_PC`, `fetch_valid_o = 0`, `fetch_pc_o` and `fetch_instr_o = 0` (queue storage cleared), `inflight_q = 0`.
- **First issue:** at the first rising edge after `rstn_i` deasserts.
- **Latency:** address presented in cycle N, data on `imem_instr_i` in N+1, queued at end of N+1, so `fetch_valid_o` is high in N+2 (2 cycles).
- **Redirect asserted in cycle R:**
  - `imem_pc_o = target` in R+1.
  - `fetch_valid_o` stays 0 in R+1 and R+2.
  - First target instruction appears in R+3.
- **Throughput:** 1 instruction per cycle with `dec_ready_i` held high and `FQ_DEPTH >= 2`.
- **Stall:** with `dec_ready_i` low, issue stops once count plus inflight reaches `FQ_DEPTH`. Head outputs stay stable while valid and not popped.
- **Reset asserted mid-operation:** asynchronously returns every register to its reset value. No in-flight data survives.

## Configuration
- `TARTARUGA_FETCH_MISALIGN_CHECK_EN`:
  - **Defined:**
    - Adds an output `fetch_misaligned_o` (1 bit) travelling with each queue entry.
    - A redirect whose `redirect_pc_i[1:0] != 0` sets `pc_q` to the target, issues no memory request, and pushes one entry {target, `32'h0000_0013` (NOP)} with `fetch_misaligned_o = 1`.
    - Fetch then halts until the next redirect.
  - **Not defined:** the port is absent, and misaligned targets are fetched with the low bits passed unmodified.

## Test plan
- **Reset and stream:** reset with `RESET_PC = 0`, memory word i = i, `dec_ready_i = 1` -> `fetch_valid_o` rises 2 cycles after the first edge; pc/instr pairs are (0,0), (4,1), (8,2)… on consecutive cycles.
- **Backpressure:** hold `dec_ready_i = 0` for 5 cycles mid-stream -> head stays (8,2); at most 2 entries are queued; after release, the sequence resumes at (12,3) with no gap or duplicate.
- **Redirect:** pulse `redirect_valid_i` with target `32'h40` in cycle R while 2 entries are queued -> `fetch_valid_o = 0` in R+1 and R+2; (`0x40`, word 16) appears in R+3.
- **Redirect with stall:** redirect while `dec_ready_i = 0` and the queue is full -> queue is emptied, and no stale PC ever appears after the redirect.
- **Wrap:** redirect to `32'hFFFF_FFF8` -> fetched PCs are `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`.
- **Async reset mid-stream:** assert `rstn_i` low asynchronously mid-stream -> `fetch_valid_o` drops immediately; after release, fetch restarts at `RESET_PC`. With the macro defined, a redirect to `32'h42` yields one entry with misaligned flag 1 and no further valid entries.
